// File: rtl/qq_cmd_issuer.sv
// qq_cmd_issuer: buffers ENQ/DEQ/REPL commands and issues them to qq_top as strobes,
// tracking occupancy, rejecting illegal commands and flagging flag/occupancy mismatch.
package pq_pkg;
  typedef logic [15:0] kv_t;
endpackage

module qq_cmd_issuer
  import pq_pkg::*;
#(
  parameter int W       = 8,
  parameter int DEPTH   = 4,
  parameter int MIN_GAP = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  kv_t                    cmd_kv,
  output logic                   enq,
  output logic                   deq,
  output logic                   repl,
  output kv_t                    lt_i,
  input  logic                   rdy_t,
  input  logic                   full_t,
  input  logic                   empty_t,
  output logic [$clog2(W+1)-1:0] occ,
  output logic                   rej,
  output logic [1:0]             rej_op,
  output logic                   err
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(W+1);
  localparam int GW = $clog2(MIN_GAP+1);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t          state_q;
  logic [AW:0]     wr_q, rd_q;
  logic [GW-1:0]   gap_q;
  logic [OW-1:0]   occ_q, occ_d;
  logic            enq_q, deq_q, repl_q, rej_q, err_q;
  logic [1:0]      rej_op_q;
  kv_t             lt_q;
  logic [1:0]      op_mem [DEPTH];
  kv_t             kv_mem [DEPTH];
  logic [1:0]      head_op;
  kv_t             head_kv;
  logic            fifo_full, fifo_empty, push, pop, illegal, issue, occ_max, occ_zero;
  assign fifo_full  = (wr_q ^ rd_q) == {1'b1, {AW{1'b0}}};
  assign fifo_empty = wr_q == rd_q;
  assign cmd_ready  = !fifo_full;
  assign push       = cmd_valid && !fifo_full && cmd_op != 2'b00;
  assign head_op    = op_mem[rd_q[AW-1:0]];
  assign head_kv    = kv_mem[rd_q[AW-1:0]];
  assign occ_max    = occ_q == OW'(W);
  assign occ_zero   = occ_q == '0;
  assign illegal    = head_op == 2'b01 ? occ_max : occ_zero;
  // Illegal heads are dropped without waiting for qq_top; legal ones need rdy_t.
  assign pop        = state_q == IDLE && !fifo_empty && (illegal || rdy_t);
  assign issue      = pop && !illegal;
  always_comb
    occ_d = !issue ? occ_q : head_op == 2'b01 ? occ_q + OW'(1) : head_op == 2'b10 ? occ_q - OW'(1) : occ_q;
  always_ff @(posedge clk)
    if (push) begin
      op_mem[wr_q[AW-1:0]] <= cmd_op;
      kv_mem[wr_q[AW-1:0]] <= cmd_kv;
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_q + (AW+1)'(push);
      rd_q <= rd_q + (AW+1)'(pop);
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q  <= IDLE;
      gap_q    <= '0;
      enq_q    <= 1'b0;
      deq_q    <= 1'b0;
      repl_q   <= 1'b0;
      rej_q    <= 1'b0;
      rej_op_q <= 2'b00;
      lt_q     <= '0;
      occ_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      enq_q    <= issue && head_op == 2'b01;
      deq_q    <= issue && head_op == 2'b10;
      repl_q   <= issue && head_op == 2'b11;
      rej_q    <= pop && illegal;
      rej_op_q <= (pop && illegal) ? head_op : 2'b00;
      occ_q    <= occ_d;
      if (issue) lt_q <= head_kv;
      if (state_q == IDLE && rdy_t && (full_t != occ_max || empty_t != occ_zero)) err_q <= 1'b1;
      if (state_q == IDLE) begin
        if (issue) begin
          state_q <= WAIT;
          gap_q   <= GW'(MIN_GAP);
        end
      end else if (gap_q != '0) gap_q <= gap_q - GW'(1);
      else if (rdy_t) state_q <= IDLE;
    end
  assign enq    = enq_q;
  assign deq    = deq_q;
  assign repl   = repl_q;
  assign rej    = rej_q;
  assign rej_op = rej_op_q;
  assign lt_i   = lt_q;
  assign occ    = occ_q;
  assign err    = err_q;
endmodule

// File: tb/tb_qq_cmd_issuer.sv
// tb_qq_cmd_issuer: directed and random stimulus checked against a queue-level model of the issuer.
module tb_qq_cmd_issuer;
  import pq_pkg::*;
  localparam int W = 8, DEPTH = 4, MIN_GAP = 2;
  logic clk = 0, rst = 1, cmd_valid = 0, cmd_ready;
  logic [1:0] cmd_op = 0;
  kv_t cmd_kv = '0;
  logic enq, deq, repl, rej, err, rdy_t = 0, full_t, empty_t;
  kv_t lt_i;
  logic [3:0] occ;
  logic [1:0] rej_op;
  typedef struct {logic [1:0] op; kv_t kv;} cmd_t;
  cmd_t q[$];
  int occ_m = 0, cyc = 0, due = 0, must = 0, checks = 0, failures = 0, rej_seen = 0;
  bit mon_en = 0, err_skip = 0, force_full = 0;

  qq_cmd_issuer #(.W(W), .DEPTH(DEPTH), .MIN_GAP(MIN_GAP)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_kv(cmd_kv), .enq(enq), .deq(deq), .repl(repl), .lt_i(lt_i), .rdy_t(rdy_t),
    .full_t(full_t), .empty_t(empty_t), .occ(occ), .rej(rej), .rej_op(rej_op), .err(err));

  always #5 clk = ~clk;
  // A well-behaved qq_top whose flags follow the model occupancy.
  assign full_t  = force_full || occ_m == W;
  assign empty_t = occ_m == 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin : mon
    cmd_t c, h;
    bit pv, pr, legal;
    int pre_n, n;
    if (mon_en && rst) begin
      pv = cmd_valid && cmd_ready && cmd_op != 2'b00;
      c.op = cmd_op;
      c.kv = cmd_kv;
      pr = rdy_t;
      pre_n = q.size();
      cyc++;
      if (!pr && must < cyc + 2) must = cyc + 2;
      #1;
      n = int'(enq) + int'(deq) + int'(repl) + int'(rej);
      chk("one_event", n <= 1, 1);
      if (n != 0) begin
        chk("spacing", cyc >= due, 1);
        if (pre_n == 0) chk("spurious", n, 0);
        else begin
          h = q.pop_front();
          legal = h.op == 2'b01 ? occ_m < W : occ_m > 0;
          if (!legal) begin
            chk("rej", rej, 1);
            chk("rej_op", rej_op, h.op);
            rej_seen++;
            due = cyc + 1;
            must = cyc + 1;
          end else begin
            chk("strobe", {enq, deq, repl}, h.op == 2'b01 ? 3'b100 : h.op == 2'b10 ? 3'b010 : 3'b001);
            chk("lt_i", lt_i, h.kv);
            chk("rdy_at_issue", pr, 1);
            occ_m += h.op == 2'b01 ? 1 : h.op == 2'b10 ? -1 : 0;
            due = cyc + MIN_GAP + 2;
            must = due;
          end
        end
      end else if (pre_n != 0 && cyc >= must) chk("stall", n, 1);
      if (pv) q.push_back(c);
      chk("occ", occ, occ_m);
      chk("cmd_ready", cmd_ready, q.size() < DEPTH);
      if (!err_skip) chk("err", err, 0);
    end
  end

  task automatic do_reset(input int hold);
    mon_en = 0;
    cmd_valid = 0;
    force_full = 0;
    rst = 0;
    #1;
    chk("rst_strobes", {enq, deq, repl, rej}, 0);
    chk("rst_err", err, 0);
    chk("rst_rej_op", rej_op, 0);
    chk("rst_lt_i", lt_i, 0);
    chk("rst_occ", occ, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    q.delete();
    occ_m = 0;
    due = 0;
    must = 0;
    repeat (hold) @(negedge clk);
    rst = 1;
    mon_en = 1;
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [1:0] op, input kv_t kv);
    int t = 0;
    bit ok = 0;
    cmd_valid = 1;
    cmd_op = op;
    cmd_kv = kv;
    while (!ok && t < 100) begin
      @(posedge clk);
      ok = cmd_ready;
      t++;
    end
    if (!ok) chk("send_timeout", 0, 1);
    @(negedge clk);
    cmd_valid = 0;
  endtask

  task automatic drain();
    int t = 0;
    while ((q.size() != 0 || cyc < due) && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk("drain", q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    #2;
    do_reset(2);
    rdy_t = 1;
    send(2'b01, 16'd11);
    @(posedge clk);
    #3;
    do_reset(1);
    send(2'b01, 16'd5);
    @(posedge clk);
    #2;
    chk("t2_enq", {enq, deq, repl, rej}, 4'b1000);
    chk("t2_lt_i", lt_i, 5);
    chk("t2_occ", occ, 1);
    @(posedge clk);
    #2;
    chk("t2_enq_pulse", enq, 0);
    chk("t2_lt_hold", lt_i, 5);
    @(negedge clk);
    rdy_t = 0;
    send(2'b01, 16'd10);
    send(2'b01, 16'd3);
    send(2'b01, 16'd20);
    send(2'b01, 16'd2);
    chk("t3_full_ready", cmd_ready, 0);
    rdy_t = 1;
    drain();
    chk("t3_occ", occ, 5);
    do_reset(1);
    send(2'b10, 16'd0);
    @(posedge clk);
    #2;
    chk("t4_rej", rej, 1);
    chk("t4_rej_op", rej_op, 2'b10);
    chk("t4_deq", deq, 0);
    chk("t4_occ", occ, 0);
    @(negedge clk);
    send(2'b01, 16'd7);
    drain();
    repeat (7) send(2'b01, kv_t'($urandom));
    drain();
    chk("t5_occ_full", occ, 8);
    send(2'b01, 16'd27);
    @(posedge clk);
    #2;
    chk("t5_rej", rej, 1);
    chk("t5_rej_op", rej_op, 2'b01);
    chk("t5_occ", occ, 8);
    @(negedge clk);
    send(2'b11, 16'd9);
    @(posedge clk);
    #2;
    chk("t5_repl", {enq, deq, repl}, 3'b001);
    chk("t5_repl_lt", lt_i, 9);
    chk("t5_repl_occ", occ, 8);
    @(negedge clk);
    repeat (8) send(2'b10, kv_t'($urandom));
    drain();
    chk("t5_occ_empty", occ, 0);
    repeat (3) send(2'b01, kv_t'($urandom));
    drain();
    err_skip = 1;
    force_full = 1;
    @(posedge clk);
    #2;
    chk("t6_err_set", err, 1);
    @(negedge clk);
    force_full = 0;
    repeat (3) @(negedge clk);
    chk("t6_err_sticky", err, 1);
    do_reset(1);
    err_skip = 0;
    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 9);
      rdy_t = $urandom_range(0, 3) != 0;
      cmd_valid = $urandom_range(0, 1);
      cmd_op = i < 300 ? (r < 6 ? 2'b01 : r < 8 ? 2'b11 : r < 9 ? 2'b10 : 2'b00)
                       : (r < 6 ? 2'b10 : r < 8 ? 2'b11 : r < 9 ? 2'b01 : 2'b00);
      cmd_kv = kv_t'($urandom);
      @(negedge clk);
    end
    cmd_valid = 0;
    rdy_t = 1;
    drain();
    chk("rand_rejects_seen", rej_seen > 1, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
